// File: rtl/multi_chan_pio.sv
`default_nettype none
// ============================================================================
// Module   : multi_chan_pio
// Brief    : Avalon-MM PIO slave with atomic set/clear outputs, synchronised
//            edge-capturing inputs and a masked level interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module multi_chan_pio #(
    parameter int               WIDTH       = 10,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               EDGE_TYPE   = 0,
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    localparam logic [2:0] c_ADDR_DATA   = 3'd0;
    localparam logic [2:0] c_ADDR_INPUT  = 3'd1;
    localparam logic [2:0] c_ADDR_MASK   = 3'd2;
    localparam logic [2:0] c_ADDR_EDGE   = 3'd3;
    localparam logic [2:0] c_ADDR_OUTSET = 3'd4;
    localparam logic [2:0] c_ADDR_OUTCLR = 3'd5;

    localparam int                  c_WARM_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [c_WARM_W-1:0] c_WARM_INIT = c_WARM_W'(SYNC_STAGES + 1);
    localparam logic [c_WARM_W-1:0] c_WARM_ONE  = c_WARM_W'(1);

    logic [WIDTH-1:0]    r_sync [SYNC_STAGES];
    logic [WIDTH-1:0]    r_prev;
    logic [WIDTH-1:0]    r_data;
    logic [WIDTH-1:0]    r_mask;
    logic [WIDTH-1:0]    r_cap;
    logic                r_irq;
    logic [c_WARM_W-1:0] r_warm;

    logic                w_we;
    logic [WIDTH-1:0]    w_wdata;
    logic [WIDTH-1:0]    w_sync;
    logic [WIDTH-1:0]    w_edge_raw;
    logic [WIDTH-1:0]    w_edge;
    logic [WIDTH-1:0]    w_w1c;

    assign w_we    = chipselect & ~write_n;
    assign w_wdata = writedata[WIDTH-1:0];
    assign w_sync  = r_sync[SYNC_STAGES-1];

    generate
        if (WIDTH < 32) begin : g_unused_wdata
            logic w_unused_hi;
            assign w_unused_hi = ^writedata[31:WIDTH];
        end
    endgenerate

    generate
        if (EDGE_TYPE == 0) begin : g_edge_rise
            assign w_edge_raw = w_sync & ~r_prev;
        end else if (EDGE_TYPE == 1) begin : g_edge_fall
            assign w_edge_raw = ~w_sync & r_prev;
        end else begin : g_edge_any
            assign w_edge_raw = w_sync ^ r_prev;
        end
    endgenerate

    // Edges are ignored until the synchroniser has filled with real input data.
    assign w_edge = (r_warm == '0) ? w_edge_raw : '0;
    assign w_w1c  = (w_we && address == c_ADDR_EDGE) ? w_wdata : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_prev <= '0;
            r_warm <= c_WARM_INIT;
        end else begin
            r_sync[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= w_sync;
            if (r_warm != '0) begin
                r_warm <= r_warm - c_WARM_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= RESET_VALUE;
            r_mask <= '0;
        end else if (w_we) begin
            case (address)
                c_ADDR_DATA:   r_data <= w_wdata;
                c_ADDR_OUTSET: r_data <= r_data | w_wdata;
                c_ADDR_OUTCLR: r_data <= r_data & ~w_wdata;
                c_ADDR_MASK:   r_mask <= w_wdata;
                default:       ;
            endcase
        end
    end

    // A new edge takes priority over a simultaneous write-1-to-clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cap <= '0;
            r_irq <= 1'b0;
        end else begin
            r_cap <= (r_cap & ~w_w1c) | w_edge;
            r_irq <= |(r_cap & r_mask);
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            c_ADDR_DATA:  readdata[WIDTH-1:0] = r_data;
            c_ADDR_INPUT: readdata[WIDTH-1:0] = w_sync;
            c_ADDR_MASK:  readdata[WIDTH-1:0] = r_mask;
            c_ADDR_EDGE:  readdata[WIDTH-1:0] = r_cap;
            default:      readdata = '0;
        endcase
    end

    assign out_port = r_data;
    assign irq      = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_multi_chan_pio.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_multi_chan_pio
// Brief    : Directed bench for multi_chan_pio with a cycle-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_chan_pio;

    localparam int           W  = 10;
    localparam int           S  = 2;
    localparam logic [W-1:0] RV = 10'h155;

    logic          clk;
    logic          reset;
    logic [2:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic [W-1:0]  in_port;
    logic [W-1:0]  out_port;
    logic          irq;

    int n_pass  = 0;
    int n_total = 0;
    bit cmp_en  = 0;

    multi_chan_pio #(
        .WIDTH       (W),
        .RESET_VALUE (RV),
        .EDGE_TYPE   (0),
        .SYNC_STAGES (S)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .out_port   (out_port),
        .irq        (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: in_port samples indexed by clock edges since reset release.
    logic [W-1:0] m_hist [0:4095];
    logic [W-1:0] m_data, m_mask, m_cap;
    logic         m_irq;
    int           m_n;

    function automatic logic [W-1:0] hv(input int i);
        return (i <= 0) ? '0 : m_hist[i];
    endfunction

    function automatic logic [31:0] exp_rd(input logic [2:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            3'd0: r[W-1:0] = m_data;
            3'd1: r[W-1:0] = hv(m_n - S + 1);
            3'd2: r[W-1:0] = m_mask;
            3'd3: r[W-1:0] = m_cap;
            default: r = '0;
        endcase
        return r;
    endfunction

    always @(posedge clk or posedge reset) begin
        logic [W-1:0] rise, wd;
        bit we;
        if (reset) begin
            m_data = RV;
            m_mask = '0;
            m_cap  = '0;
            m_irq  = 1'b0;
            m_n    = 0;
        end else begin
            we   = chipselect && !write_n;
            wd   = writedata[W-1:0];
            m_n  = m_n + 1;
            m_hist[m_n] = in_port;
            rise = (m_n >= S + 2) ? (hv(m_n - S) & ~hv(m_n - S - 1)) : '0;
            m_irq = |(m_cap & m_mask);
            if (we && address == 3'd0) m_data = wd;
            if (we && address == 3'd4) m_data = m_data | wd;
            if (we && address == 3'd5) m_data = m_data & ~wd;
            if (we && address == 3'd2) m_mask = wd;
            m_cap = (m_cap & ~((we && address == 3'd3) ? wd : '0)) | rise;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model out_port", {22'd0, out_port}, {22'd0, m_data});
            chk("model irq", {31'd0, irq}, {31'd0, m_irq});
            chk("model readdata", readdata, exp_rd(address));
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #2;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
        address = a;
        #1;
        chk(name, readdata, exp);
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset      = 1'b1;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = '0;
        repeat (3) @(posedge clk);
        #2;
        reset  = 1'b0;
        cmp_en = 1'b1;

        // Reset state
        chk("reset out_port", {22'd0, out_port}, 32'h155);
        chk("reset irq", {31'd0, irq}, 32'd0);
        rd(3'd0, 32'h155, "reset DATA");
        for (int a = 1; a < 8; a++) rd(3'(a), 32'd0, "reset reg zero");
        in_port = 10'h2A5;
        idle(2);
        rd(3'd1, 32'h2A5, "INPUT tracks in_port");
        in_port = '0;
        idle(4);

        // Output set/clear
        wr(3'd0, 32'hFFFF_F0F0);
        chk("DATA write", {22'd0, out_port}, 32'h0F0);
        wr(3'd4, 32'h003);
        chk("OUTSET", {22'd0, out_port}, 32'h0F3);
        wr(3'd5, 32'h030);
        chk("OUTCLEAR", {22'd0, out_port}, 32'h0C3);
        rd(3'd4, 32'd0, "OUTSET reads 0");
        rd(3'd5, 32'd0, "OUTCLEAR reads 0");
        rd(3'd0, 32'h0C3, "DATA readback");

        // Rising edge capture and interrupt latency
        wr(3'd3, 32'h3FF);
        wr(3'd2, 32'h001);
        idle(3);
        in_port = 10'h001;
        idle(1);
        rd(3'd3, 32'd0, "capture after k");
        rd(3'd3, 32'd0, "capture after k+1");
        chk("irq after k+2", {31'd0, irq}, 32'd0);
        rd(3'd3, 32'h001, "capture after k+2");
        chk("irq after k+3", {31'd0, irq}, 32'd1);
        wr(3'd3, 32'h001);
        idle(1);
        chk("irq after W1C", {31'd0, irq}, 32'd0);

        // W1C colliding with a new edge on the same bit
        in_port = 10'h005;
        idle(4);
        rd(3'd3, 32'h004, "bit2 captured");
        in_port = 10'h001;
        idle(4);
        in_port = 10'h005;
        idle(2);
        wr(3'd3, 32'h004);
        rd(3'd3, 32'h004, "edge beats W1C");
        wr(3'd3, 32'h004);
        rd(3'd3, 32'd0, "plain W1C clears");

        // Asynchronous reset in the middle of a write with irq high
        in_port = 10'h004;
        idle(4);
        in_port = 10'h005;
        idle(4);
        chk("irq before reset", {31'd0, irq}, 32'd1);
        address    = 3'd0;
        writedata  = 32'h3FF;
        chipselect = 1'b1;
        write_n    = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        chk("async reset out_port", {22'd0, out_port}, 32'h155);
        chk("async reset irq", {31'd0, irq}, 32'd0);
        address = 3'd3;
        #0.5;
        chk("async reset capture", readdata, 32'd0);
        chipselect = 1'b0;
        write_n    = 1'b1;
        idle(2);

        // Inputs held high through reset release
        in_port = 10'h3FF;
        idle(2);
        reset = 1'b0;
        idle(6);
        rd(3'd3, 32'd0, "warm-up suppression");
        rd(3'd1, 32'h3FF, "INPUT held high");
        chk("irq after warm-up", {31'd0, irq}, 32'd0);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
